// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the iterative signed divider:
//   DIV_SIZE  - default operand width in bits (even, >= 4)
//   state_t   - FSM state encoding (IDLE, CALC, FIX)
//   cnt_width - width of the step counter for a given operand width
//   CNT_W     - counter width for the default operand width
// -----------------------------------------------------------------------------
package div_pkg;

    localparam int DIV_SIZE = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    function automatic int cnt_width(input int n);
        return $clog2(n);
    endfunction

    localparam int CNT_W = cnt_width(DIV_SIZE);

endpackage

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational restoring-division step: shift the next dividend bit into
// the partial remainder, trial-subtract the divisor magnitude and keep either
// the difference or the shifted remainder.
// Ports:
//   rem_in       - partial remainder entering the step (unsigned magnitude)
//   b_mag        - divisor magnitude
//   dividend_bit - next dividend magnitude bit, MSB first
//   rem_out      - partial remainder leaving the step
//   q_bit        - quotient bit produced by the step
// -----------------------------------------------------------------------------
module div_step
    import div_pkg::*;
#(
    parameter int div_size = DIV_SIZE
) (
    input  logic [div_size-1:0] rem_in,
    input  logic [div_size-1:0] b_mag,
    input  logic                dividend_bit,
    output logic [div_size-1:0] rem_out,
    output logic                q_bit
);

    logic        [div_size:0] shifted;
    logic signed [div_size:0] trial;

    // rem_in < b_mag <= 2^(div_size-1), so the shifted value stays below
    // 2^div_size and the difference always fits a div_size+1 bit signed word;
    // its top bit is therefore a clean "went negative" indicator.
    always_comb begin
        shifted = {rem_in, dividend_bit};
        trial   = $signed(shifted - {1'b0, b_mag});
        q_bit   = ~trial[div_size];
        rem_out = q_bit ? trial[div_size-1:0] : shifted[div_size-1:0];
    end

endmodule

// File: rtl/div_32.sv
// -----------------------------------------------------------------------------
// div_32
// Iterative signed divider (truncating toward zero, remainder takes the sign
// of the dividend). One restoring step per clock, then a sign-fix cycle.
// Ports:
//   clk      - rising-edge clock
//   reset    - asynchronous, active-low reset
//   start    - request; sampled only while idle
//   A_in     - dividend, two's complement
//   B_in     - divisor, two's complement
//   busy     - high while a division is in progress (CALC or FIX)
//   done     - one-cycle pulse when Q, R and div_zero are updated
//   Q        - quotient, registered
//   R        - remainder, registered
//   div_zero - last result had a zero divisor
// -----------------------------------------------------------------------------
module div_32
    import div_pkg::*;
#(
    parameter int div_size = DIV_SIZE
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic signed [div_size-1:0] A_in,
    input  logic signed [div_size-1:0] B_in,
    output logic                       busy,
    output logic                       done,
    output logic signed [div_size-1:0] Q,
    output logic signed [div_size-1:0] R,
    output logic                       div_zero
);

    localparam int                   CW       = cnt_width(div_size);
    localparam logic [CW-1:0]        CNT_LAST = CW'(div_size - 1);
    localparam logic [CW-1:0]        CNT_ONE  = CW'(1);
    localparam logic [div_size-1:0]  ONE      = div_size'(1);

    function automatic logic [div_size-1:0] negate(input logic [div_size-1:0] v);
        return ~v + ONE;
    endfunction

    // The most negative value negates to itself, whose unsigned reading is
    // exactly its magnitude, so no extra bit is needed.
    function automatic logic [div_size-1:0] magnitude(input logic signed [div_size-1:0] v);
        return v[div_size-1] ? negate(v) : v;
    endfunction

    state_t state, state_next;

    logic signed [div_size-1:0] a_val;
    logic                       a_neg;
    logic                       b_neg;
    logic        [div_size-1:0] a_shift;
    logic        [div_size-1:0] b_mag;
    logic        [div_size-1:0] rem;
    logic        [div_size-1:0] quot;
    logic        [CW-1:0]       cnt;

    logic        [div_size-1:0] step_rem;
    logic                       step_q;

    div_step #(
        .div_size (div_size)
    ) u_step (
        .rem_in       (rem),
        .b_mag        (b_mag),
        .dividend_bit (a_shift[div_size-1]),
        .rem_out      (step_rem),
        .q_bit        (step_q)
    );

    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CALC;
            CALC:    if (cnt == CNT_LAST) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy = (state != IDLE);
    end

    // operand capture, iteration datapath and result registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_val    <= '0;
            a_neg    <= 1'b0;
            b_neg    <= 1'b0;
            a_shift  <= '0;
            b_mag    <= '0;
            rem      <= '0;
            quot     <= '0;
            cnt      <= '0;
            done     <= 1'b0;
            Q        <= '0;
            R        <= '0;
            div_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_val   <= A_in;
                        a_neg   <= A_in[div_size-1];
                        b_neg   <= B_in[div_size-1];
                        a_shift <= magnitude(A_in);
                        b_mag   <= magnitude(B_in);
                        rem     <= '0;
                        quot    <= '0;
                        cnt     <= '0;
                    end
                end
                CALC: begin
                    rem     <= step_rem;
                    quot    <= {quot[div_size-2:0], step_q};
                    a_shift <= {a_shift[div_size-2:0], 1'b0};
                    // wraps back to zero on the last step
                    cnt     <= cnt + CNT_ONE;
                end
                FIX: begin
                    done <= 1'b1;
                    if (b_mag == '0) begin
                        // zero divisor overrides any sign handling
                        Q        <= '1;
                        R        <= a_val;
                        div_zero <= 1'b1;
                    end else begin
                        Q        <= (a_neg ^ b_neg) ? negate(quot) : quot;
                        R        <= a_neg ? negate(rem) : rem;
                        div_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_32.sv
module tb_div_32;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] A_in;
    logic [31:0] B_in;
    logic        busy;
    logic        done;
    logic [31:0] Q;
    logic [31:0] R;
    logic        div_zero;

    int tests = 0;
    int fails = 0;

    div_32 #(.div_size(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .A_in     (A_in),
        .B_in     (B_in),
        .busy     (busy),
        .done     (done),
        .Q        (Q),
        .R        (R),
        .div_zero (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: plain 64-bit signed arithmetic (SV / and % truncate toward
    // zero and give the remainder the dividend's sign).
    task automatic model(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r, output logic dz);
        longint sa, sb, lq, lr;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (sb == 0) begin
            q  = 32'hFFFF_FFFF;
            r  = a;
            dz = 1'b1;
        end else begin
            lq = sa / sb;
            lr = sa % sb;
            q  = lq[31:0];
            r  = lr[31:0];
            dz = 1'b0;
        end
    endtask

    // Called at a falling edge. Raises start with (a, b); the next rising edge
    // is the sampling edge. Inputs are scrambled while busy; at cycle 'glitch'
    // (if > 0) a second start with 9/3 is pulsed and must be ignored.
    task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input int glitch);
        logic [31:0] eq, er;
        logic        edz;
        int          done_at;
        int          busy_cnt;
        model(a, b, eq, er, edz);
        A_in  = a;
        B_in  = b;
        start = 1'b1;
        done_at  = 0;
        busy_cnt = 0;
        for (int c = 1; c <= 60 && done_at == 0; c++) begin
            @(negedge clk);
            if (done) begin
                done_at = c;
            end else begin
                if (busy) busy_cnt++;
                start = (c == glitch);
                if (c == glitch) begin
                    A_in = 32'd9;
                    B_in = 32'd3;
                end else begin
                    A_in = $urandom;
                    B_in = $urandom;
                end
            end
        end
        check({tag, ".latency"}, 32'(done_at), 32'd34);
        check({tag, ".busy_cycles"}, 32'(busy_cnt), 32'd33);
        check({tag, ".busy_at_done"}, {31'd0, busy}, 32'd0);
        check({tag, ".Q"}, Q, eq);
        check({tag, ".R"}, R, er);
        check({tag, ".div_zero"}, {31'd0, div_zero}, {31'd0, edz});
    endtask

    task automatic quiet_cycles(input string tag, input int n);
        int dones;
        dones = 0;
        start = 1'b0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if (done) dones++;
        end
        check({tag, ".no_done"}, 32'(dones), 32'd0);
    endtask

    initial begin
        logic [31:0] ra, rb;
        reset = 1'b0;
        start = 1'b0;
        A_in  = '0;
        B_in  = '0;
        repeat (3) @(negedge clk);
        check("reset.busy", {31'd0, busy}, 32'd0);
        check("reset.done", {31'd0, done}, 32'd0);
        check("reset.Q", Q, 32'd0);
        check("reset.R", R, 32'd0);
        check("reset.div_zero", {31'd0, div_zero}, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Directed cases, with literal spot checks on top of the model.
        run_div("pos", 32'd100, 32'd7, 0);
        check("pos.Q_lit", Q, 32'd14);
        check("pos.R_lit", R, 32'd2);
        run_div("mixed", -32'sd100, 32'd7, 0);
        check("mixed.Q_lit", Q, 32'hFFFF_FFF2);
        check("mixed.R_lit", R, 32'hFFFF_FFFE);
        run_div("negdiv", 32'd100, -32'sd7, 0);
        run_div("bothneg", -32'sd100, -32'sd7, 0);
        run_div("divzero", 32'd7, 32'd0, 0);
        check("divzero.Q_lit", Q, 32'hFFFF_FFFF);
        run_div("overflow", 32'h8000_0000, 32'hFFFF_FFFF, 0);
        check("overflow.Q_lit", Q, 32'h8000_0000);

        // Outputs hold while idle.
        quiet_cycles("hold", 5);
        check("hold.Q", Q, 32'h8000_0000);
        check("hold.R", R, 32'd0);

        // Start pulsed mid-CALC is ignored and not queued.
        run_div("ignored", 32'd100, 32'd7, 10);
        check("ignored.Q_lit", Q, 32'd14);
        quiet_cycles("ignored", 40);

        // Back-to-back: second start raised during the done cycle.
        run_div("b2b_first", 32'd100, 32'd7, 0);
        run_div("b2b_second", 32'd9, 32'd3, 0);
        check("b2b.Q_lit", Q, 32'd3);

        // Asynchronous reset in the middle of CALC.
        start = 1'b0;
        @(negedge clk);
        A_in  = 32'd100;
        B_in  = 32'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("midrst.busy_before", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        #1;
        check("midrst.busy", {31'd0, busy}, 32'd0);
        check("midrst.done", {31'd0, done}, 32'd0);
        check("midrst.Q", Q, 32'd0);
        check("midrst.R", R, 32'd0);
        check("midrst.div_zero", {31'd0, div_zero}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        quiet_cycles("midrst", 40);

        // Recovery after reset.
        run_div("recover", 32'd9, 32'd3, 0);
        check("recover.Q_lit", Q, 32'd3);

        // Randomized operands, with occasional corner values mixed in.
        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 15));
                2: ra = 32'h8000_0000;
                3: rb = -32'($urandom_range(1, 15));
                default: ;
            endcase
            run_div("rand", ra, rb, 0);
        end

        start = 1'b0;
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
